// File: rtl/mips_top.sv
// mips_top: single-cycle 32-bit MIPS subset processor with on-chip program ROM and data RAM.
// Each instruction completes in one clock. The ROM holds a fixed self-checking program whose
// final store writes 7 to address 84.
//
// Ports:
//   clk        in   1   system clock, all state updates on the rising edge
//   reset      in   1   asynchronous active-low reset (0 = in reset)
//   writedata  out  32  register rt value of the current instruction (store data)
//   dataadr    out  32  ALU result of the current instruction (data address for lw/sw)
//   memwrite   out  1   high while the current instruction is sw; RAM writes at next rising edge
//
// Supported: add, sub, and, or, slt, lw, sw, beq, addi, j. Anything else is a no-op.

module mips_top (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] writedata,
    output logic [31:0] dataadr,
    output logic        memwrite
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpJ     = 6'h02;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt
    } alu_ctl_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q  [32];
    logic [31:0] ram_q [64];

    // ------------------------------------------------------------------
    // Fetch
    // ------------------------------------------------------------------
    logic [31:0] instr;

    always_comb begin
        instr = '0;
        case (pc_q[7:2])
            6'd0:    instr = 32'h20020005;  // addi $2,$0,5
            6'd1:    instr = 32'h2003000c;  // addi $3,$0,12
            6'd2:    instr = 32'h2067fff7;  // addi $7,$3,-9
            6'd3:    instr = 32'h00e22025;  // or   $4,$7,$2
            6'd4:    instr = 32'h00642824;  // and  $5,$3,$4
            6'd5:    instr = 32'h00a42820;  // add  $5,$5,$4
            6'd6:    instr = 32'h10a7000a;  // beq  $5,$7,end
            6'd7:    instr = 32'h0064202a;  // slt  $4,$3,$4
            6'd8:    instr = 32'h10800001;  // beq  $4,$0,around
            6'd9:    instr = 32'h20050000;  // addi $5,$0,0
            6'd10:   instr = 32'h00e2202a;  // slt  $4,$7,$2
            6'd11:   instr = 32'h00853820;  // add  $7,$4,$5
            6'd12:   instr = 32'h00e23822;  // sub  $7,$7,$2
            6'd13:   instr = 32'hac670044;  // sw   $7,68($3)
            6'd14:   instr = 32'h8c020050;  // lw   $2,80($0)
            6'd15:   instr = 32'h08000011;  // j    end
            6'd16:   instr = 32'h20020001;  // addi $2,$0,1
            6'd17:   instr = 32'hac020054;  // sw   $2,84($0)
            default: instr = '0;
        endcase
    end

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm_ext;

    assign opcode  = instr[31:26];
    assign rs_addr = instr[25:21];
    assign rt_addr = instr[20:16];
    assign rd_addr = instr[15:11];
    assign funct   = instr[5:0];
    assign imm_ext = {{16{instr[15]}}, instr[15:0]};

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic     reg_write;
    logic     reg_dst;
    logic     alu_src;
    logic     branch;
    logic     mem_write_dec;
    logic     mem_to_reg;
    logic     jump;
    alu_ctl_e alu_ctl;

    always_comb begin
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src       = 1'b0;
        branch        = 1'b0;
        mem_write_dec = 1'b0;
        mem_to_reg    = 1'b0;
        jump          = 1'b0;
        alu_ctl       = AluAdd;
        case (opcode)
            OpRtype: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                case (funct)
                    FnAdd:   alu_ctl = AluAdd;
                    FnSub:   alu_ctl = AluSub;
                    FnAnd:   alu_ctl = AluAnd;
                    FnOr:    alu_ctl = AluOr;
                    FnSlt:   alu_ctl = AluSlt;
                    // Unknown funct (including the all-zero word) is a no-op.
                    default: reg_write = 1'b0;
                endcase
            end
            OpLw: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
            end
            OpSw: begin
                alu_src       = 1'b1;
                mem_write_dec = 1'b1;
            end
            OpBeq: begin
                branch  = 1'b1;
                alu_ctl = AluSub;
            end
            OpAddi: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            OpJ: begin
                jump = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file read and ALU
    // ------------------------------------------------------------------
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;

    assign rd1   = (rs_addr == 5'd0) ? 32'd0 : rf_q[rs_addr];
    assign rd2   = (rt_addr == 5'd0) ? 32'd0 : rf_q[rt_addr];
    assign alu_b = alu_src ? imm_ext : rd2;

    always_comb begin
        alu_result = '0;
        case (alu_ctl)
            AluAdd:  alu_result = rd1 + alu_b;
            AluSub:  alu_result = rd1 - alu_b;
            AluAnd:  alu_result = rd1 & alu_b;
            AluOr:   alu_result = rd1 | alu_b;
            AluSlt:  alu_result = {31'd0, $signed(rd1) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);

    // ------------------------------------------------------------------
    // Data memory and write-back
    // ------------------------------------------------------------------
    logic [31:0] ram_rdata;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    assign ram_rdata = ram_q[alu_result[7:2]];
    assign wr_addr   = reg_dst ? rd_addr : rt_addr;
    assign wr_data   = mem_to_reg ? ram_rdata : alu_result;

    assign writedata = rd2;
    assign dataadr   = alu_result;
    // Stores are suppressed while reset is held.
    assign memwrite  = mem_write_dec & reset;

    // ------------------------------------------------------------------
    // Next PC
    // ------------------------------------------------------------------
    logic [31:0] pc_plus4;
    logic [31:0] pc_branch;
    logic [31:0] pc_jump;

    assign pc_plus4  = pc_q + 32'd4;
    assign pc_branch = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign pc_jump   = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        pc_d = pc_plus4;
        if (jump) begin
            pc_d = pc_jump;
        end else if (branch && alu_zero) begin
            pc_d = pc_branch;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (reg_write && (wr_addr != 5'd0)) begin
            rf_q[wr_addr] <= wr_data;
        end
    end

    // RAM is deliberately not reset so its contents survive a mid-program reset.
    always_ff @(posedge clk) begin
        if (memwrite) begin
            ram_q[alu_result[7:2]] <= rd2;
        end
    end

endmodule

// File: tb/tb_mips_top.sv
// tb_mips_top: directed self-checking bench for mips_top. Runs the built-in program, checks
// the PC trace, the two stores, selected register values, and a mid-program reset.
// Cycle c (1-based) is the c-th falling edge after reset release; cycle 1 shows PC=0.

module tb_mips_top;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] writedata;
    logic [31:0] dataadr;
    logic        memwrite;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] pc_tab [16];

    mips_top dut (
        .clk       (clk),
        .reset     (reset),
        .writedata (writedata),
        .dataadr   (dataadr),
        .memwrite  (memwrite)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_pc(input int c);
        if (c <= 16) return pc_tab[c-1];
        return 32'd68 + 32'(4 * (c - 16));
    endfunction

    // Assert reset (if not already), check the reset state, then release after a rising edge.
    task automatic reset_pulse(input string tag, input bit check_ram);
        reset = 1'b0;
        #1;
        check_eq({tag, " pc"}, dut.pc_q, 32'd0);
        check_eq({tag, " memwrite"}, {31'd0, memwrite}, 32'd0);
        check_eq({tag, " dataadr"}, dataadr, 32'd5);
        check_eq({tag, " writedata"}, writedata, 32'd0);
        for (int r = 0; r < 32; r++) begin
            check_eq($sformatf("%s reg%0d", tag, r), dut.rf_q[r], 32'd0);
        end
        if (check_ram) begin
            check_eq({tag, " ram80"}, dut.ram_q[20], 32'd7);
            check_eq({tag, " ram84"}, dut.ram_q[21], 32'd7);
        end
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic run_seq(input string tag, input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            check_eq($sformatf("%s c%0d pc", tag, c), dut.pc_q, exp_pc(c));
            check_eq($sformatf("%s c%0d memwrite", tag, c), {31'd0, memwrite},
                     (c == 13 || c == 16) ? 32'd1 : 32'd0);
            check_eq($sformatf("%s c%0d reg0", tag, c), dut.rf_q[0], 32'd0);
            if (c == 13) begin
                check_eq({tag, " sw1 dataadr"}, dataadr, 32'd80);
                check_eq({tag, " sw1 writedata"}, writedata, 32'd7);
                check_eq({tag, " sw1 reg2"}, dut.rf_q[2], 32'd5);
                check_eq({tag, " sw1 reg3"}, dut.rf_q[3], 32'd12);
                check_eq({tag, " sw1 reg4"}, dut.rf_q[4], 32'd1);
                check_eq({tag, " sw1 reg5"}, dut.rf_q[5], 32'd11);
                check_eq({tag, " sw1 reg7"}, dut.rf_q[7], 32'd7);
            end
            if (c == 16) begin
                check_eq({tag, " sw2 dataadr"}, dataadr, 32'd84);
                check_eq({tag, " sw2 writedata"}, writedata, 32'd7);
                check_eq({tag, " lw reg2"}, dut.rf_q[2], 32'd7);
            end
            if (c == 20) begin
                check_eq({tag, " end reg2"}, dut.rf_q[2], 32'd7);
                check_eq({tag, " end reg5"}, dut.rf_q[5], 32'd11);
                check_eq({tag, " end ram84"}, dut.ram_q[21], 32'd7);
            end
        end
    endtask

    initial begin
        pc_tab = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28,
                   32'd32, 32'd40, 32'd44, 32'd48, 32'd52, 32'd56, 32'd60, 32'd68};
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_pulse("init", 1'b0);

        run_seq("run1", 20);

        // Fresh start, then interrupt the program during cycle 10.
        @(negedge clk);
        #2;
        reset_pulse("restart", 1'b1);
        run_seq("run2", 10);
        #2;
        reset_pulse("mid", 1'b1);
        run_seq("run3", 20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
